mouse_pos_ctl: RTL and testbench
================================

MOUSE_POS_CTL -- requirements
Module: mouse_pos_ctl

Interface
REQ-001 Parameter H_MAX, default 1023: largest legal cursor x (pixels).
REQ-002 Parameter V_MAX, default 767: largest legal cursor y (lines).
REQ-003 Parameter DB_CYCLES, default 65000: debounce stable-time in clk cycles (used only with MOUSE_DEBOUNCE_EN).
REQ-004 clk  in  1  pixel clock; sole clock; all logic on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 mouse_x  in  12  raw x from PS/2 mouse decoder, unsigned.
REQ-007 mouse_y  in  12  raw y from PS/2 mouse decoder, unsigned.
REQ-008 mouse_left  in  1  raw left-button level.
REQ-009 mouse_valid  in  1  one-cycle strobe, mouse_x/mouse_y valid.
REQ-010 vblnk  in  1  vertical blank from timing chain.
REQ-011 xpos  out  12  frame-stable cursor x to the mouse draw stage.
REQ-012 ypos  out  12  frame-stable cursor y to the mouse draw stage.
REQ-013 left_held  out  1  conditioned left-button level.
REQ-014 click  out  1  one-cycle pulse on left-button press.
REQ-015 click_x, click_y  out  12 each  committed position at the press.
REQ-016 pending  out  1  high while a captured sample awaits commit.

Function
REQ-017 Capture: on mouse_valid, shadow_x SHALL load min(mouse_x, H_MAX) and shadow_y SHALL load min(mouse_y, V_MAX), with the comparison unsigned and 12-bit.
REQ-018 A later mouse_valid before commit SHALL overwrite the shadow registers; only the newest sample is committed.
REQ-019 The FSM SHALL have states IDLE, PENDING and COMMIT; IDLE->PENDING on mouse_valid; PENDING->COMMIT on vblnk rising edge; COMMIT->PENDING if mouse_valid is high that cycle, else COMMIT->IDLE.
REQ-020 The vblnk rising edge SHALL be detected against a registered copy of vblnk; a vblnk rise in IDLE SHALL not change state or outputs.
REQ-021 In COMMIT, xpos/ypos SHALL load the shadow values; outputs SHALL change 2 clk after the vblnk 0->1 input transition and never during active video.
REQ-022 Simultaneous mouse_valid and commit: the commit SHALL use the pre-existing shadow values, and the new sample SHALL become pending for the next frame.
REQ-023 pending SHALL equal (state != IDLE) registered, i.e. high in PENDING and COMMIT.
REQ-024 click SHALL pulse for exactly one cycle on each 0->1 transition of left_held.
REQ-025 click_x/click_y SHALL load the current xpos/ypos in the same cycle click is asserted and hold otherwise.
REQ-026 Without debounce, left_held SHALL be mouse_left through a 2-flop synchronizer (2-cycle latency).

Reset
REQ-027 While rst_n=0: state=IDLE, xpos=ypos=0, shadow=0, click_x=click_y=0, click=0, left_held=0, pending=0, vblnk register=0, debounce counter=0.
REQ-028 Reset asserted mid-PENDING SHALL discard the captured sample; the first post-reset vblnk rise SHALL not commit.

Configuration
REQ-029 Macro MOUSE_DEBOUNCE_EN defined: left_held SHALL change only after the synchronized button differs from left_held for DB_CYCLES consecutive cycles; the counter clears on any reversion.
REQ-030 MOUSE_DEBOUNCE_EN undefined: no counter logic SHALL be generated; REQ-026 applies.

Structure
REQ-031 Shared vga_pkg SHALL hold the state enum typedef (IDLE/PENDING/COMMIT) and default screen limits (1023, 767) used for H_MAX/V_MAX defaults.
REQ-032 Sub-module btn_cond (synchronizer plus optional debounce) SHALL produce left_held; FSM and registers stay in mouse_pos_ctl.

Verification
REQ-033 mouse_valid with x=500,y=300 in active video -> pending=1, xpos/ypos unchanged until vblnk rise, then 500/300 two cycles later, pending=0.
REQ-034 mouse_x=2000, mouse_y=4095 -> after commit xpos=1023, ypos=767.
REQ-035 Three valid strobes (10,10),(20,20),(30,30) in one frame -> single commit of 30/30.
REQ-036 mouse_valid (40,40) in the COMMIT cycle with shadow (30,30) -> xpos=30 this frame, pending stays 1, xpos=40 next frame.
REQ-037 Left press with xpos=100,ypos=200 -> click high one cycle, click_x=100, click_y=200; with MOUSE_DEBOUNCE_EN and DB_CYCLES=16, glitch of 5 cycles -> no click.
REQ-038 rst_n pulsed low while PENDING -> all outputs 0, next vblnk rise leaves xpos/ypos=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA-side definitions: cursor FSM state encoding, default screen limits
// and the coordinate clamp used when capturing raw mouse samples.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  localparam int unsigned SCREEN_H_MAX = 1023;
  localparam int unsigned SCREEN_V_MAX = 767;

  function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/mouse_pos_ctl_btn_cond.sv
// Left-button conditioning: 2-flop synchronizer, plus an optional stable-time
// debounce filter when MOUSE_DEBOUNCE_EN is defined.
module btn_cond #(
  parameter int unsigned DB_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic held_o
);

  logic sync1_q, sync2_q;

  if (DB_CYCLES < 1) begin : g_db_range_chk
    $error("btn_cond: DB_CYCLES must be at least 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef MOUSE_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          held_q;

  // Count consecutive cycles of disagreement; any reversion restarts the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      held_q <= 1'b0;
    end else if (sync2_q != held_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        held_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign held_o = held_q;
`else
  assign held_o = sync2_q;
`endif

endmodule

// File: rtl/mouse_pos_ctl.sv
// Cursor position controller: captures clamped mouse samples and commits them to
// xpos/ypos only during vertical blank. Optional button debounce: MOUSE_DEBOUNCE_EN.
module mouse_pos_ctl
  import vga_pkg::*;
#(
  parameter int unsigned H_MAX     = SCREEN_H_MAX,
  parameter int unsigned V_MAX     = SCREEN_V_MAX,
  parameter int unsigned DB_CYCLES = 65000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  input  logic        mouse_left,
  input  logic        mouse_valid,
  input  logic        vblnk,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left_held,
  output logic        click,
  output logic [11:0] click_x,
  output logic [11:0] click_y,
  output logic        pending
);

  localparam logic [11:0] HLim = 12'(H_MAX);
  localparam logic [11:0] VLim = 12'(V_MAX);

  state_e      state_q;
  logic [11:0] shadow_x_q, shadow_y_q;
  logic [11:0] xpos_q, ypos_q;
  logic        vblnk_q;
  logic        pending_q;
  logic        vblnk_rise_d;
  logic        held_prev_q;
  logic        click_q;
  logic [11:0] click_x_q, click_y_q;

  assign vblnk_rise_d = vblnk & ~vblnk_q;

  btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_cond (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (mouse_left),
    .held_o(left_held)
  );

  // Commit reads the old shadow while a same-cycle strobe overwrites it,
  // so that strobe naturally rolls over into the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shadow_x_q <= '0;
      shadow_y_q <= '0;
      xpos_q     <= '0;
      ypos_q     <= '0;
      vblnk_q    <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
      if (mouse_valid) begin
        shadow_x_q <= clamp12(mouse_x, HLim);
        shadow_y_q <= clamp12(mouse_y, VLim);
      end
      case (state_q)
        IDLE: begin
          if (mouse_valid) begin
            state_q   <= PENDING;
            pending_q <= 1'b1;
          end
        end
        PENDING: begin
          if (vblnk_rise_d) state_q <= COMMIT;
        end
        COMMIT: begin
          xpos_q <= shadow_x_q;
          ypos_q <= shadow_y_q;
          if (mouse_valid) begin
            state_q <= PENDING;
          end else begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_prev_q <= 1'b0;
      click_q     <= 1'b0;
      click_x_q   <= '0;
      click_y_q   <= '0;
    end else begin
      held_prev_q <= left_held;
      click_q     <= left_held & ~held_prev_q;
      if (left_held & ~held_prev_q) begin
        click_x_q <= xpos_q;
        click_y_q <= ypos_q;
      end
    end
  end

  assign xpos    = xpos_q;
  assign ypos    = ypos_q;
  assign pending = pending_q;
  assign click   = click_q;
  assign click_x = click_x_q;
  assign click_y = click_y_q;

endmodule

// File: tb/tb_mouse_pos_ctl.sv
// Directed testbench for mouse_pos_ctl: table-driven capture/commit vectors plus
// hand-written sequences for collisions, clicks and reset. Honors MOUSE_DEBOUNCE_EN.
module tb_mouse_pos_ctl;

`ifdef MOUSE_DEBOUNCE_EN
  localparam int unsigned TbDb = 16;
`else
  localparam int unsigned TbDb = 65000;
`endif

  logic        clk;
  logic        rst_n;
  logic [11:0] mouse_x, mouse_y;
  logic        mouse_left, mouse_valid, vblnk;
  logic [11:0] xpos, ypos, click_x, click_y;
  logic        left_held, click, pending;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [11:0] mx;
    logic [11:0] my;
    logic [11:0] ex;
    logic [11:0] ey;
  } vec_t;

  vec_t vecs[6];

  mouse_pos_ctl #(.H_MAX(1023), .V_MAX(767), .DB_CYCLES(TbDb)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .mouse_left (mouse_left),
    .mouse_valid(mouse_valid),
    .vblnk      (vblnk),
    .xpos       (xpos),
    .ypos       (ypos),
    .left_held  (left_held),
    .click      (click),
    .click_x    (click_x),
    .click_y    (click_y),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] x, input logic [11:0] y);
    mouse_x     = x;
    mouse_y     = y;
    mouse_valid = 1'b1;
    tick();
    mouse_valid = 1'b0;
  endtask

  task automatic commitFrame();
    vblnk = 1'b1;
    tick();
    tick();
    vblnk = 1'b0;
    tick();
  endtask

  initial begin
    logic [11:0] prevX, prevY;
    bit          sawClick;

    vecs[0] = '{12'd500,  12'd300,  12'd500,  12'd300};
    vecs[1] = '{12'd2000, 12'd4095, 12'd1023, 12'd767};
    vecs[2] = '{12'd1023, 12'd767,  12'd1023, 12'd767};
    vecs[3] = '{12'd1024, 12'd768,  12'd1023, 12'd767};
    vecs[4] = '{12'd0,    12'd0,    12'd0,    12'd0};
    vecs[5] = '{12'd1022, 12'd766,  12'd1022, 12'd766};

    rst_n = 1'b0; mouse_x = '0; mouse_y = '0;
    mouse_left = 1'b0; mouse_valid = 1'b0; vblnk = 1'b0;
    #2;
    checkOutput("rst_xpos", int'(xpos), 0);
    checkOutput("rst_ypos", int'(ypos), 0);
    checkOutput("rst_pending", int'(pending), 0);
    checkOutput("rst_click", int'(click), 0);
    checkOutput("rst_left_held", int'(left_held), 0);
    checkOutput("rst_click_x", int'(click_x), 0);
    checkOutput("rst_click_y", int'(click_y), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    prevX = '0; prevY = '0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].mx, vecs[i].my);
      checkOutput($sformatf("v%0d_pending_cap", i), int'(pending), 1);
      checkOutput($sformatf("v%0d_xpos_hold", i), int'(xpos), int'(prevX));
      vblnk = 1'b1;
      tick();
      checkOutput($sformatf("v%0d_xpos_1clk", i), int'(xpos), int'(prevX));
      checkOutput($sformatf("v%0d_ypos_1clk", i), int'(ypos), int'(prevY));
      tick();
      checkOutput($sformatf("v%0d_xpos", i), int'(xpos), int'(vecs[i].ex));
      checkOutput($sformatf("v%0d_ypos", i), int'(ypos), int'(vecs[i].ey));
      checkOutput($sformatf("v%0d_pending_clr", i), int'(pending), 0);
      vblnk = 1'b0;
      tick();
      prevX = vecs[i].ex; prevY = vecs[i].ey;
    end

    // Newest of several strobes wins.
    applyStimulus(12'd10, 12'd10);
    applyStimulus(12'd20, 12'd20);
    applyStimulus(12'd30, 12'd30);
    tick();
    checkOutput("multi_xpos_hold", int'(xpos), 1022);
    commitFrame();
    checkOutput("multi_xpos", int'(xpos), 30);
    checkOutput("multi_ypos", int'(ypos), 30);

    // vblnk rise while idle must not disturb anything.
    applyStimulus(12'd5, 12'd5);
    commitFrame();
    commitFrame();
    checkOutput("idle_vblnk_xpos", int'(xpos), 5);
    checkOutput("idle_vblnk_pending", int'(pending), 0);

    // Strobe landing in the commit cycle.
    applyStimulus(12'd30, 12'd30);
    vblnk = 1'b1;
    tick();
    mouse_x = 12'd40; mouse_y = 12'd40; mouse_valid = 1'b1;
    tick();
    mouse_valid = 1'b0;
    checkOutput("coll_xpos_now", int'(xpos), 30);
    checkOutput("coll_pending", int'(pending), 1);
    tick(); tick();
    checkOutput("coll_xpos_hold", int'(xpos), 30);
    vblnk = 1'b0;
    tick();
    commitFrame();
    checkOutput("coll_xpos_next", int'(xpos), 40);
    checkOutput("coll_ypos_next", int'(ypos), 40);
    checkOutput("coll_pending_clr", int'(pending), 0);

    applyStimulus(12'd100, 12'd200);
    commitFrame();
`ifdef MOUSE_DEBOUNCE_EN
    sawClick = 1'b0;
    mouse_left = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    mouse_left = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (click) sawClick = 1'b1;
    end
    checkOutput("db_glitch_click", int'(sawClick), 0);
    checkOutput("db_glitch_held", int'(left_held), 0);
    mouse_left = 1'b1;
    for (int i = 0; i < 40 && !click; i++) tick();
    checkOutput("db_click", int'(click), 1);
    checkOutput("db_click_x", int'(click_x), 100);
    checkOutput("db_click_y", int'(click_y), 200);
    tick();
    checkOutput("db_click_once", int'(click), 0);
    mouse_left = 1'b0;
    for (int i = 0; i < 25; i++) tick();
`else
    mouse_left = 1'b1;
    tick();
    checkOutput("held_lat1", int'(left_held), 0);
    tick();
    checkOutput("held_lat2", int'(left_held), 1);
    checkOutput("click_early", int'(click), 0);
    tick();
    checkOutput("click_pulse", int'(click), 1);
    checkOutput("click_x", int'(click_x), 100);
    checkOutput("click_y", int'(click_y), 200);
    tick();
    checkOutput("click_once", int'(click), 0);
    applyStimulus(12'd300, 12'd400);
    commitFrame();
    checkOutput("click_x_hold", int'(click_x), 100);
    mouse_left = 1'b0;
    tick(); tick(); tick();
    checkOutput("held_release", int'(left_held), 0);
    mouse_left = 1'b1;
    tick(); tick(); tick();
    checkOutput("click2_pulse", int'(click), 1);
    checkOutput("click2_x", int'(click_x), 300);
    checkOutput("click2_y", int'(click_y), 400);
    mouse_left = 1'b0;
    tick(); tick(); tick();
`endif

    // Reset while a sample is pending discards it.
    applyStimulus(12'd700, 12'd500);
    checkOutput("prerst_pending", int'(pending), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_xpos", int'(xpos), 0);
    checkOutput("midrst_ypos", int'(ypos), 0);
    checkOutput("midrst_pending", int'(pending), 0);
    checkOutput("midrst_click_x", int'(click_x), 0);
    checkOutput("midrst_click_y", int'(click_y), 0);
    tick();
    rst_n = 1'b1;
    tick();
    commitFrame();
    checkOutput("postrst_xpos", int'(xpos), 0);
    checkOutput("postrst_ypos", int'(ypos), 0);
    checkOutput("postrst_pending", int'(pending), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
